// File: rtl/next_pc_unit.sv
// IF-stage fetch PC generator: priority select among EX redirect, RAS, BTB and
// sequential PC, with stall hold, buffered redirect and a circular return-address stack.
module next_pc_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              PC_STEP   = 4,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_target,
   input  logic            pred_is_call,
   input  logic            pred_is_ret,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] next_pc,
   output logic [1:0]      pc_src,
   output logic            ras_empty
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   logic [RAS_DEPTH-1:0][XLEN-1:0] ras_q;
   logic [PW-1:0]   top_q;
   logic [CW-1:0]   cnt_q;
   logic            pend_vld_q;
   logic [XLEN-1:0] pend_pc_q;

   logic            redir_active;
   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] seq_pc;
   logic            ras_hit;
   logic            advance, do_push, do_repl, do_pop;

   assign redir_active = redirect_valid | pend_vld_q;
   assign redir_pc     = redirect_valid ? redirect_pc : pend_pc_q;
   assign seq_pc       = pc + STEP;
   assign ras_empty    = (cnt_q == '0);
   assign ras_hit      = pred_is_ret & ~ras_empty;

   always_comb begin
      next_pc = seq_pc;
      pc_src  = 2'd0;
      if (redir_active) begin
         next_pc = redir_pc;
         pc_src  = 2'd3;
      end else if (ras_hit) begin
         next_pc = ras_q[top_q];
         pc_src  = 2'd2;
      end else if (pred_taken) begin
         next_pc = pred_target;
         pc_src  = 2'd1;
      end
   end

   // Call+ret with a live entry replaces the top in place; with an empty stack it is a plain push.
   assign advance = ~stall & ~redir_active;
   assign do_push = advance & pred_is_call & ~ras_hit;
   assign do_repl = advance & pred_is_call &  ras_hit;
   assign do_pop  = advance & ~pred_is_call & ras_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
      end else if (!stall) begin
         pc         <= next_pc;
         pend_vld_q <= 1'b0;
      end else if (redirect_valid) begin
         pend_vld_q <= 1'b1;
         pend_pc_q  <= redirect_pc;
      end
   end

   // Pointer wraps naturally at RAS_DEPTH; overflow silently overwrites the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ras_q <= '0;
         top_q <= '0;
         cnt_q <= '0;
      end else if (do_push) begin
         ras_q[top_q + PW'(1)] <= seq_pc;
         top_q                 <= top_q + PW'(1);
         if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
      end else if (do_repl) begin
         ras_q[top_q] <= seq_pc;
      end else if (do_pop) begin
         top_q <= top_q - PW'(1);
         cnt_q <= cnt_q - CW'(1);
      end
   end
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: reset, sequential, BTB, call/ret, stall+redirect,
// RAS overflow, address wrap and async reset with a pending redirect.
module tb_next_pc_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect_valid, pred_taken, pred_is_call, pred_is_ret;
   logic [31:0] redirect_pc, pred_target;
   logic [31:0] pc, next_pc;
   logic [1:0]  pc_src;
   logic        ras_empty;

   int n_cmp  = 0;
   int n_fail = 0;

   next_pc_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .pred_is_call(pred_is_call), .pred_is_ret(pred_is_ret),
      .pc(pc), .next_pc(next_pc), .pc_src(pc_src), .ras_empty(ras_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; redirect_pc = '0;
      pred_taken = 0; pred_target = '0; pred_is_call = 0; pred_is_ret = 0;
   endtask

   // Load pc via a one-edge redirect (RAS untouched).
   task automatic jump(input logic [31:0] tgt);
      redirect_valid = 1; redirect_pc = tgt;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 0;
      #2;
      chk("rst_pc", pc, 32'h0);
      chk("rst_next_pc", next_pc, 32'h4);
      chk("rst_pc_src", {30'd0, pc_src}, 32'd0);
      chk("rst_ras_empty", {31'd0, ras_empty}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1;
      #1 chk("free_pc0", pc, 32'h0);

      // free-run
      step(); chk("free_pc1", pc, 32'h4);
      step(); chk("free_pc2", pc, 32'h8);
      chk("free_src", {30'd0, pc_src}, 32'd0);
      step(); chk("free_pc3", pc, 32'hC);
      chk("free_empty", {31'd0, ras_empty}, 32'd1);
      step(); chk("free_pc4", pc, 32'h10);

      // BTB taken
      pred_taken = 1; pred_target = 32'h200; #1;
      chk("btb_next", next_pc, 32'h200);
      chk("btb_src", {30'd0, pc_src}, 32'd1);
      step(); idle();
      chk("btb_pc", pc, 32'h200);

      // call / return
      redirect_valid = 1; redirect_pc = 32'h40; #1;
      chk("redir_src", {30'd0, pc_src}, 32'd3);
      step(); idle();
      chk("redir_pc", pc, 32'h40);
      pred_is_call = 1; pred_taken = 1; pred_target = 32'h300; #1;
      chk("call_next", next_pc, 32'h300);
      step(); idle();
      chk("call_pc", pc, 32'h300);
      chk("call_empty", {31'd0, ras_empty}, 32'd0);
      pred_is_ret = 1; #1;
      chk("ras_top", next_pc, 32'h44);
      pred_is_ret = 0;
      repeat (4) step();
      chk("seq_to_310", pc, 32'h310);
      pred_is_ret = 1; #1;
      chk("ret_next", next_pc, 32'h44);
      chk("ret_src", {30'd0, pc_src}, 32'd2);
      step(); idle();
      chk("ret_pc", pc, 32'h44);
      chk("ret_empty", {31'd0, ras_empty}, 32'd1);

      // stall with two redirects: latest wins
      jump(32'h80);
      stall = 1; redirect_valid = 1; redirect_pc = 32'h500;
      step(); chk("stall1_pc", pc, 32'h80);
      redirect_pc = 32'h600;
      step(); chk("stall2_pc", pc, 32'h80);
      redirect_valid = 0; redirect_pc = 32'h0; #1;
      chk("pend_next", next_pc, 32'h600);
      chk("pend_src", {30'd0, pc_src}, 32'd3);
      step(); chk("stall3_pc", pc, 32'h80);
      stall = 0;
      step(); chk("release_pc", pc, 32'h600);
      chk("release_src", {30'd0, pc_src}, 32'd0);
      step(); chk("after_pc", pc, 32'h604);

      // RAS overflow: 5 calls into a 4-deep stack
      jump(32'h0);
      for (int i = 0; i < 5; i++) begin
         pred_is_call = 1; pred_taken = 1;
         pred_target = (i == 4) ? 32'h1000 : 32'(i + 1) << 8;
         step();
      end
      idle();
      chk("ovf_pc", pc, 32'h1000);
      pred_is_ret = 1; #1; chk("pop1", next_pc, 32'h404); step();
      chk("pop1_pc", pc, 32'h404);
      #1 chk("pop2", next_pc, 32'h304); step();
      #1 chk("pop3", next_pc, 32'h204); step();
      #1 chk("pop4", next_pc, 32'h104);
      chk("pop4_src", {30'd0, pc_src}, 32'd2);
      step();
      chk("pop_empty", {31'd0, ras_empty}, 32'd1);
      #1 chk("pop5_next", next_pc, 32'h108);
      chk("pop5_src", {30'd0, pc_src}, 32'd0);
      step(); idle();
      chk("pop5_pc", pc, 32'h108);

      // wrap
      jump(32'hFFFF_FFFC);
      #1 chk("wrap_next", next_pc, 32'h0);
      step(); chk("wrap_pc", pc, 32'h0);
      step(); chk("wrap_pc1", pc, 32'h4);

      // async reset drops pending redirect
      stall = 1; redirect_valid = 1; redirect_pc = 32'h700;
      step();
      redirect_valid = 0; redirect_pc = 32'h0;
      chk("pend_hold_pc", pc, 32'h4);
      #2 rst_n = 0;
      #1 chk("arst_pc", pc, 32'h0);
      chk("arst_src", {30'd0, pc_src}, 32'd0);
      #1 rst_n = 1; stall = 0;
      #1 chk("arst_next", next_pc, 32'h4);
      step(); chk("arst_after_pc", pc, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
